instruction_fetch_unit: RTL and testbench

- Producer side of the scheduler's instruction-input handshake (`inst_valid` / `inst_in` / `inst_ready`).
- On a start command, reads a program of N consecutive instruction words from the instruction SRAM, starting at `base_addr`.
- Fetched words go into a small prefetch FIFO and are presented to the instruction scheduler under valid/ready flow control.
- Sits between the instruction SRAM and the instruction scheduler; controlled by the NPU controller.

---
 rtl/instruction_fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: streams a program of consecutive instruction words
// from the instruction SRAM into a small prefetch FIFO and hands them to the
// instruction scheduler under valid/ready flow control.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_abort      program-start pulse, synchronous flush/cancel
//   i_base_addr           first instruction word address (sampled on start)
//   i_inst_count          program length in instructions (sampled on start)
//   o_mem_rd_en           SRAM read strobe
//   o_mem_addr            SRAM word address
//   i_mem_rd_data         SRAM read data, valid one cycle after o_mem_rd_en
//   o_inst_valid          instruction available to the scheduler
//   o_inst_out            instruction word (FIFO head)
//   i_inst_ready          scheduler can accept
//   o_busy                high outside IDLE
//   o_done                one-cycle pulse after the last hand-over
//   o_delivered_count     instructions handed over in the current/last program

package instruction_fetch_unit_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dst;
        logic [15:0] imm;
    } instruction_t;
endpackage

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned PF_DEPTH   = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_inst_count,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  instruction_t          i_mem_rd_data,
    output logic                  o_inst_valid,
    output instruction_t          o_inst_out,
    input  logic                  i_inst_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_delivered_count
);

    localparam int unsigned PTR_W = $clog2(PF_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_delivered;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_inflight;
    logic                  r_valid;
    instruction_t          r_fifo [PF_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    state_t                w_state_n;
    logic [ADDR_WIDTH-1:0] w_base_n;
    logic [CNT_WIDTH-1:0]  w_count_n;
    logic [CNT_WIDTH-1:0]  w_issued_n;
    logic [CNT_WIDTH-1:0]  w_delivered_n;
    logic                  w_done_n;
    logic                  w_inflight_n;
    logic [OCC_W-1:0]      w_occ_n;
    logic                  w_flush;
    logic                  w_rd_en_n;
    logic [ADDR_WIDTH-1:0] w_addr_n;
    logic                  w_push;
    logic                  w_pop;

    // Data for a read issued last cycle lands this cycle; abort discards it.
    assign w_push = r_inflight && !i_abort;
    assign w_pop  = r_valid && i_inst_ready && !i_abort;

    // Next-state and next-register computation.
    always_comb begin
        w_state_n     = r_state;
        w_base_n      = r_base;
        w_count_n     = r_count;
        w_issued_n    = r_issued + CNT_WIDTH'(r_mem_rd_en);
        w_delivered_n = r_delivered + CNT_WIDTH'(w_pop);
        w_done_n      = 1'b0;
        w_inflight_n  = r_mem_rd_en;
        w_occ_n       = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        w_flush       = 1'b0;

        if (i_abort) begin
            w_state_n     = ST_IDLE;
            w_flush       = 1'b1;
            w_inflight_n  = 1'b0;
            w_occ_n       = '0;
            w_delivered_n = r_delivered;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_base_n      = i_base_addr;
                        w_count_n     = i_inst_count;
                        w_issued_n    = '0;
                        w_delivered_n = '0;
                        if (i_inst_count == '0) begin
                            w_done_n = 1'b1;
                        end else begin
                            w_state_n = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (r_mem_rd_en && (w_issued_n == r_count)) begin
                        w_state_n = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_inflight_n && (w_occ_n == '0)) begin
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end

        // Credit rule: FIFO entries plus the read in flight never exceed depth.
        w_rd_en_n = (w_state_n == ST_FETCH) && (w_issued_n < w_count_n) &&
                    ((w_occ_n + OCC_W'(w_inflight_n)) < OCC_W'(PF_DEPTH));
        w_addr_n  = ADDR_WIDTH'(w_base_n + ADDR_WIDTH'(w_issued_n));
    end

    // Control and status registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_inflight  <= 1'b0;
            r_valid     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
        end else begin
            r_state     <= w_state_n;
            r_base      <= w_base_n;
            r_count     <= w_count_n;
            r_issued    <= w_issued_n;
            r_delivered <= w_delivered_n;
            r_done      <= w_done_n;
            r_busy      <= (w_state_n != ST_IDLE);
            r_mem_rd_en <= w_rd_en_n;
            if (w_rd_en_n) begin
                r_mem_addr <= w_addr_n;
            end
            r_inflight  <= w_inflight_n;
            r_valid     <= (w_occ_n != '0);
            r_occ       <= w_occ_n;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while the occupancy is zero.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= i_mem_rd_data;
        end
    end

    assign o_mem_rd_en       = r_mem_rd_en;
    assign o_mem_addr        = r_mem_addr;
    assign o_inst_valid      = r_valid;
    assign o_inst_out        = r_fifo[r_rd_ptr];
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_delivered_count = r_delivered;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: an SRAM model returning
// address-tagged words, a transaction-level reference model compared every
// cycle, and directed scenarios with hand-computed expectations.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam int unsigned PF_DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [15:0]  base_addr;
    logic [15:0]  inst_count;
    logic         mem_rd_en;
    logic [15:0]  mem_addr;
    instruction_t mem_rd_data;
    logic         inst_valid;
    instruction_t inst_out;
    logic         inst_ready;
    logic         busy;
    logic         done;
    logic [15:0]  delivered_count;

    instruction_fetch_unit #(
        .ADDR_WIDTH(16), .PF_DEPTH(PF_DEPTH), .CNT_WIDTH(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_base_addr(base_addr), .i_inst_count(inst_count),
        .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr), .i_mem_rd_data(mem_rd_data),
        .o_inst_valid(inst_valid), .o_inst_out(inst_out), .i_inst_ready(inst_ready),
        .o_busy(busy), .o_done(done), .o_delivered_count(delivered_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instruction_t tag(input logic [15:0] a);
        return instruction_t'({~a, a});
    endfunction

    // SRAM: one-cycle read latency, word content derived from its address.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= tag(mem_addr);
    end

    int n_cmp;
    int n_fail;

    // Reference model state (program-level view).
    int           m_phase;      // 0 idle, 1 fetching, 2 draining
    logic [15:0]  m_base;
    int           m_count;
    int           m_issued;
    int           m_delivered;
    instruction_t m_q[$];
    bit           m_inflight;
    logic [15:0]  m_inflight_addr;
    bit           m_done;

    // Observation logs for directed checks.
    int           rd_cnt;
    int           done_cnt;
    logic [15:0]  addr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_base = '0; m_count = 0; m_issued = 0; m_delivered = 0;
        m_q.delete(); m_inflight = 1'b0; m_inflight_addr = '0; m_done = 1'b0;
    endtask

    task automatic clear_logs();
        rd_cnt = 0; done_cnt = 0; addr_log.delete();
    endtask

    // Compare this cycle's outputs with the model, then advance the model.
    task automatic cycle_check();
        bit          e_rd;
        logic [15:0] e_addr;
        bit          pop;
        e_rd   = (m_phase == 1) && (m_issued < m_count) &&
                 ((m_q.size() + int'(m_inflight)) < PF_DEPTH);
        e_addr = m_base + 16'(m_issued);

        chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
        if (e_rd) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("inst_out", 32'(inst_out), 32'(m_q[0]));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("delivered_count", 32'(delivered_count), 32'(16'(m_delivered)));
        if (!rst && !abort && dut.r_inflight)
            chk("fifo_write_room",
                32'((int'(dut.r_occ) - int'(inst_valid && inst_ready)) < int'(PF_DEPTH)), 32'd1);

        if (mem_rd_en) begin rd_cnt++; addr_log.push_back(mem_addr); end
        if (done) done_cnt++;

        if (rst) begin
            model_reset();
        end else if (abort) begin
            m_phase = 0; m_q.delete(); m_inflight = 1'b0; m_done = 1'b0;
        end else begin
            pop = (m_q.size() != 0) && inst_ready;
            if (pop) begin void'(m_q.pop_front()); m_delivered++; end
            if (m_inflight) m_q.push_back(tag(m_inflight_addr));
            m_inflight = e_rd;
            m_inflight_addr = e_addr;
            if (e_rd) m_issued++;
            m_done = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_base = base_addr; m_count = int'(inst_count);
                    m_issued = 0; m_delivered = 0;
                    if (inst_count == 16'd0) m_done = 1'b1;
                    else m_phase = 1;
                end
                1: if (e_rd && m_issued == m_count) m_phase = 2;
                2: if (!m_inflight && m_q.size() == 0) begin m_phase = 0; m_done = 1'b1; end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && done_cnt == 0; i++) step();
        chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) step();
        chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic launch(input logic [15:0] b, input logic [15:0] c);
        base_addr = b; inst_count = c; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; inst_ready = 1'b0;
        base_addr = '0; inst_count = '0;
        model_reset(); clear_logs();
        repeat (3) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(inst_valid), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_delivered", 32'(delivered_count), 32'd0);

        // Basic program with the exact latency profile.
        clear_logs(); inst_ready = 1'b1;
        launch(16'h0010, 16'd5);
        chk("basic_rd_cycle1", 32'(mem_rd_en), 32'd1);
        chk("basic_addr_cycle1", 32'(mem_addr), 32'h0010);
        step();
        chk("basic_valid_cycle2", 32'(inst_valid), 32'd0);
        step();
        chk("basic_valid_cycle3", 32'(inst_valid), 32'd1);
        chk("basic_out_cycle3", 32'(inst_out), 32'hFFEF_0010);
        wait_done("basic", 40);
        chk("basic_delivered", 32'(delivered_count), 32'd5);
        chk("basic_reads", 32'(rd_cnt), 32'd5);
        chk("basic_last_addr", 32'(addr_log[4]), 32'h0014);

        // Backpressure: reads stop at the prefetch depth, head held stable.
        clear_logs(); inst_ready = 1'b0;
        launch(16'h0200, 16'd8);
        repeat (20) step();
        chk("bp_reads_capped", 32'(rd_cnt), 32'd4);
        chk("bp_valid_held", 32'(inst_valid), 32'd1);
        chk("bp_head_word", 32'(inst_out), 32'hFDFF_0200);
        inst_ready = 1'b1;
        wait_done("bp", 60);
        chk("bp_delivered", 32'(delivered_count), 32'd8);
        chk("bp_last_addr", 32'(addr_log[7]), 32'h0207);

        // Address wrap.
        clear_logs();
        launch(16'hFFFE, 16'd4);
        wait_done("wrap", 40);
        chk("wrap_addr0", 32'(addr_log[0]), 32'hFFFE);
        chk("wrap_addr1", 32'(addr_log[1]), 32'hFFFF);
        chk("wrap_addr2", 32'(addr_log[2]), 32'h0000);
        chk("wrap_addr3", 32'(addr_log[3]), 32'h0001);

        // Zero-length program.
        clear_logs();
        launch(16'h1234, 16'd0);
        chk("zero_done_next", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (4) step();
        chk("zero_no_reads", 32'(rd_cnt), 32'd0);
        chk("zero_done_once", 32'(done_cnt), 32'd1);
        chk("zero_delivered", 32'(delivered_count), 32'd0);

        // Abort after three transfers, then a clean restart.
        clear_logs();
        launch(16'h0100, 16'd10);
        for (int i = 0; i < 30 && delivered_count != 16'd3; i++) step();
        chk("abort_reached_3", 32'(delivered_count), 32'd3);
        chk("abort_read_pending", 32'(dut.r_inflight || mem_rd_en), 32'd1);
        abort = 1'b1; inst_ready = 1'b0;
        step();
        abort = 1'b0;
        chk("abort_valid", 32'(inst_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
        chk("abort_delivered", 32'(delivered_count), 32'd3);
        inst_ready = 1'b1;
        repeat (5) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_delivered_hold", 32'(delivered_count), 32'd3);
        clear_logs();
        launch(16'h0300, 16'd2);
        wait_done("restart", 30);
        chk("restart_delivered", 32'(delivered_count), 32'd2);
        chk("restart_addr0", 32'(addr_log[0]), 32'h0300);
        chk("restart_reads", 32'(rd_cnt), 32'd2);

        // Second start while busy is ignored.
        clear_logs();
        launch(16'h0400, 16'd6);
        step();
        base_addr = 16'h0500; inst_count = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("busy_start", 40);
        chk("busy_start_reads", 32'(rd_cnt), 32'd6);
        chk("busy_start_delivered", 32'(delivered_count), 32'd6);
        chk("busy_start_last_addr", 32'(addr_log[5]), 32'h0405);

        // start and abort together from IDLE.
        clear_logs();
        base_addr = 16'h0600; inst_count = 16'd3; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_rd_en", 32'(mem_rd_en), 32'd0);
        repeat (5) step();
        chk("sa_no_reads", 32'(rd_cnt), 32'd0);
        chk("sa_no_done", 32'(done_cnt), 32'd0);

        // Random ready toggling over a long program.
        clear_logs();
        launch(16'h1000, 16'd100);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            step();
        end
        inst_ready = 1'b1;
        chk("rand_done_seen", 32'(done_cnt), 32'd1);
        chk("rand_delivered", 32'(delivered_count), 32'd100);
        chk("rand_reads", 32'(rd_cnt), 32'd100);
        chk("rand_last_addr", 32'(addr_log[99]), 32'h1063);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
